// File: rtl/boot_sequencer_if.sv
// Source-ROM read port and instruction-memory write port of the boot sequencer.
// master = sequencer side, slave = ROM/imem side.
interface boot_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] src_addr;
  logic              src_req;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output src_addr, src_req, imem_we, imem_addr, imem_wdata,
    input  src_data, src_valid
  );

  modport slave (
    input  src_addr, src_req, imem_we, imem_addr, imem_wdata,
    output src_data, src_valid
  );
endinterface

// File: rtl/boot_sequencer.sv
// Program loader and run controller: copies a program into imem, holds the core in reset,
// then runs it until a self-loop halt or cycle limit. Optional checksum via BOOT_CHECKSUM_EN.
module boot_sequencer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int CNT_W      = 16,
  parameter int RESET_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [CNT_W-1:0]  cycle_limit,
  boot_sequencer_if.master  bus,
  output logic              core_reset,
  input  logic [31:0]       core_pc,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam int              HW    = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);
  localparam logic [HW-1:0]   HLAST = HW'(RESET_HOLD-1);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [ADDR_W:0]  idx, idx_inc, len, len_clamp;
  logic [CNT_W-1:0] limit, cyc_inc;
  logic [HW-1:0]    hold_cnt;
  logic [31:0]      prev_pc;
  logic             pc_vld;
  logic             start_ok, wr, last_wr, hold_end, halt, lim_hit;

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign len_clamp = (prog_len > DEPTH) ? DEPTH : prog_len;
  assign idx_inc   = idx + (ADDR_W+1)'(1);
  assign wr        = (state == LOAD) && bus.src_valid;
  assign last_wr   = wr && (idx_inc == len);
  assign hold_end  = (state == HOLD) && (hold_cnt == HLAST);
  assign cyc_inc   = (&cycles) ? cycles : cycles + CNT_W'(1);
  // pc_vld gates the first RUN edge, which only captures the PC
  assign halt      = (state == RUN) && pc_vld && (core_pc == prev_pc);
  assign lim_hit   = (state == RUN) && (limit != '0) && (cyc_inc == limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start_ok) state_nxt = (len_clamp != '0) ? LOAD : HOLD;
      LOAD:       if (last_wr)  state_nxt = HOLD;
      HOLD:       if (hold_end) state_nxt = RUN;
      RUN:        if (halt || lim_hit) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.src_req    = 1'b0;
    bus.src_addr   = idx[ADDR_W-1:0];
    bus.imem_we    = 1'b0;
    bus.imem_addr  = idx[ADDR_W-1:0];
    bus.imem_wdata = '0;
    core_reset     = 1'b1;
    busy           = 1'b0;
    unique case (state)
      LOAD: begin
        bus.src_req    = 1'b1;
        bus.imem_we    = bus.src_valid;
        bus.imem_wdata = bus.src_valid ? bus.src_data : '0;
        busy           = 1'b1;
      end
      HOLD: busy = 1'b1;
      RUN: begin
        core_reset = 1'b0;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      len      <= '0;
      limit    <= '0;
      hold_cnt <= '0;
      cycles   <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      prev_pc  <= '0;
      pc_vld   <= 1'b0;
    end else if (start_ok) begin
      idx      <= '0;
      len      <= len_clamp;
      limit    <= cycle_limit;
      hold_cnt <= '0;
      cycles   <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      pc_vld   <= 1'b0;
    end else begin
      unique case (state)
        LOAD: if (wr) idx <= idx_inc;
        HOLD: begin
          hold_cnt <= hold_cnt + HW'(1);
          pc_vld   <= 1'b0;
        end
        RUN: begin
          cycles  <= cyc_inc;
          prev_pc <= core_pc;
          pc_vld  <= 1'b1;
          if (halt)         done    <= 1'b1;
          else if (lim_hit) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        sum <= '0;
    else if (start_ok) sum <= '0;
    else if (wr)       sum <= sum + bus.src_data;
  end
  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule
